// File: rtl/row_sum_acc.sv
// row_sum_acc: row partial-sum accumulator for the conv datapath.
// Accumulates one signed product per output column over PASSES = CHANNEL*KSIZE
// passes, then presents the completed row under a valid/ready handshake and
// clears for the next row.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   clr        synchronous clear, drops the row in progress or a pending row
//   in_valid   input beat valid
//   in_ready   block can accept a beat (ACCUM state)
//   in_data    signed product for the current column
//   out_valid  completed row available (DRAIN state)
//   out_ready  consumer accepts the row
//   out_data   flattened row, column c at [c*ACC_WIDTH +: ACC_WIDTH]
//   col_cnt    column of the next accepted beat
//   pass_cnt   current pass index
//   pass_start high when col_cnt == 0
module row_sum_acc #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 32,
  parameter int IN_SIZE   = 14,
  parameter int KSIZE     = 5,
  parameter int CHANNEL   = 6,
  parameter int SAT       = 0,
  localparam int OUT_COLS = IN_SIZE - KSIZE + 1,
  localparam int PASSES   = CHANNEL * KSIZE,
  localparam int CW       = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1,
  localparam int PW       = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_COLS*ACC_WIDTH-1:0] out_data,
  output logic [CW-1:0]                 col_cnt,
  output logic [PW-1:0]                 pass_cnt,
  output logic                          pass_start
);

  typedef enum logic {ACCUM, DRAIN} state_t;

  localparam logic [CW-1:0] COL_LAST  = CW'(OUT_COLS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc [OUT_COLS];
  logic signed [ACC_WIDTH-1:0] cur;
  logic signed [ACC_WIDTH-1:0] nxt;
  logic signed [ACC_WIDTH:0]   sum;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DRAIN);
  assign pass_start = (col_cnt == '0);

  for (genvar c = 0; c < OUT_COLS; c++) begin : g_out
    assign out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[c];
  end

  // Sum at ACC_WIDTH+1 bits; overflow shows as the top two bits disagreeing.
  always_comb begin
    cur = acc[col_cnt];
    sum = {cur[ACC_WIDTH-1], cur}
        + {{(ACC_WIDTH + 1 - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    nxt = sum[ACC_WIDTH-1:0];
    if ((SAT != 0) && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
      nxt = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ACCUM;
      col_cnt  <= '0;
      pass_cnt <= '0;
      acc      <= '{default: '0};
    end else if (clr) begin
      state    <= ACCUM;
      col_cnt  <= '0;
      pass_cnt <= '0;
      acc      <= '{default: '0};
    end else if (state == ACCUM) begin
      if (in_valid) begin
        acc[col_cnt] <= nxt;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (pass_cnt == PASS_LAST) begin
            pass_cnt <= '0;
            state    <= DRAIN;
          end else begin
            pass_cnt <= pass_cnt + PW'(1);
          end
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end else if (out_ready) begin
      // Counters are already zero on entry to DRAIN.
      state <= ACCUM;
      acc   <= '{default: '0};
    end
  end

endmodule

// File: tb/tb_row_sum_acc.sv
module tb_row_sum_acc;
  localparam int OC = 10;
  localparam int NP = 30;
  localparam int SOC = 4;
  localparam int SNP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default-parameter instance
  logic         rstn, clr0, iv0, or0;
  logic [31:0]  id0;
  logic         ir0, ov0, ps0;
  logic [319:0] od0;
  logic [3:0]   cc0;
  logic [4:0]   pc0;

  row_sum_acc u0 (
    .clk(clk), .rstn(rstn), .clr(clr0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .col_cnt(cc0), .pass_cnt(pc0), .pass_start(ps0));

  // 8-bit instances, OUT_COLS=4, PASSES=2, sharing one stimulus
  logic        sclr, siv, sor;
  logic [7:0]  sid;
  logic        ir1, ov1, ps1, ir2, ov2, ps2;
  logic [31:0] od1, od2;
  logic [1:0]  cc1, cc2;
  logic        pc1, pc2;

  row_sum_acc #(.IN_WIDTH(8), .ACC_WIDTH(8), .IN_SIZE(4), .KSIZE(1),
                .CHANNEL(2), .SAT(1)) u1 (
    .clk(clk), .rstn(rstn), .clr(sclr), .in_valid(siv), .in_ready(ir1),
    .in_data(sid), .out_valid(ov1), .out_ready(sor), .out_data(od1),
    .col_cnt(cc1), .pass_cnt(pc1), .pass_start(ps1));

  row_sum_acc #(.IN_WIDTH(8), .ACC_WIDTH(8), .IN_SIZE(4), .KSIZE(1),
                .CHANNEL(2), .SAT(0)) u2 (
    .clk(clk), .rstn(rstn), .clr(sclr), .in_valid(siv), .in_ready(ir2),
    .in_data(sid), .out_valid(ov2), .out_ready(sor), .out_data(od2),
    .col_cnt(cc2), .pass_cnt(pc2), .pass_start(ps2));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint col0(input int c);
    return longint'($signed(od0[c*32 +: 32]));
  endfunction
  function automatic longint col1(input int c);
    return longint'($signed(od1[c*8 +: 8]));
  endfunction
  function automatic longint col2(input int c);
    return longint'($signed(od2[c*8 +: 8]));
  endfunction

  task automatic beat0(input logic [31:0] d);
    @(negedge clk); iv0 = 1'b1; id0 = d;
    @(posedge clk); #1;
  endtask

  task automatic beat_s(input logic [7:0] d);
    @(negedge clk); siv = 1'b1; sid = d;
    @(posedge clk); #1;
  endtask

  task automatic drain0(input string nm);
    @(negedge clk); iv0 = 1'b0; or0 = 1'b1;
    @(posedge clk); #1;
    or0 = 1'b0;
    chk({nm, "_ov_low"}, ov0, 0);
    chk({nm, "_ir_high"}, ir0, 1);
    for (int c = 0; c < OC; c++) chk({nm, "_cleared"}, col0(c), 0);
  endtask

  task automatic drain_s(input string nm);
    @(negedge clk); siv = 1'b0; sor = 1'b1;
    @(posedge clk); #1;
    sor = 1'b0;
    chk({nm, "_ov_low"}, ov1 | ov2, 0);
    chk({nm, "_ir_high"}, ir1 & ir2, 1);
    chk({nm, "_cleared"}, (od1 == '0) && (od2 == '0), 1);
  endtask

  typedef struct { int v; int es; int ew; } vec_t;
  vec_t tbl[6];

  int mdl[OC];
  int ms[SOC];
  int mw[SOC];
  logic [319:0] snap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{100, 127, -56};
    tbl[1] = '{-100, -128, 56};
    tbl[2] = '{50, 100, 100};
    tbl[3] = '{127, 127, -2};
    tbl[4] = '{-128, -128, 0};
    tbl[5] = '{-64, -128, -128};

    rstn = 1'b0; clr0 = 0; iv0 = 0; or0 = 0; id0 = '0;
    sclr = 0; siv = 0; sor = 0; sid = '0;
    #12;
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_pass_start", ps0, 1);
    chk("rst_col_cnt", cc0, 0);
    chk("rst_pass_cnt", pc0, 0);
    chk("rst_out_data", od0 == '0, 1);
    @(negedge clk); rstn = 1'b1;

    // row of ones, latency and contents
    for (int i = 0; i < OC*NP; i++) begin
      beat0(32'd1);
      if (i == OC*NP - 2) chk("ones_pre_valid", ov0, 0);
    end
    chk("ones_valid", ov0, 1);
    chk("ones_in_ready", ir0, 0);
    chk("ones_col_cnt", cc0, 0);
    chk("ones_pass_cnt", pc0, 0);
    chk("ones_pass_start", ps0, 1);
    for (int c = 0; c < OC; c++) chk("ones_col", col0(c), 30);
    drain0("ones_drain");

    // data = c - p, then backpressure with in_valid held high
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < OC; c++) beat0(32'(c - p));
    chk("cmp_valid", ov0, 1);
    for (int c = 0; c < OC; c++) chk("cmp_col", col0(c), 30*c - 435);
    snap = od0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); iv0 = 1'b1; id0 = 32'd99; or0 = 1'b0;
      @(posedge clk); #1;
      chk("bp_valid", ov0, 1);
      chk("bp_in_ready", ir0, 0);
      chk("bp_data_held", od0 == snap, 1);
    end
    drain0("bp_drain");

    // table-driven saturation/wrap vectors on the 8-bit pair
    foreach (tbl[t]) begin
      for (int i = 0; i < SOC*SNP; i++) beat_s(8'(tbl[t].v));
      chk("tbl_valid", ov1 & ov2, 1);
      for (int c = 0; c < SOC; c++) begin
        chk("tbl_sat_col", col1(c), tbl[t].es);
        chk("tbl_wrap_col", col2(c), tbl[t].ew);
      end
      drain_s("tbl_drain");
    end

    // clr coinciding with a beat at pass 3, column 4
    for (int i = 0; i < 3*OC + 4; i++) beat0(32'd7);
    chk("clr_pre_col", cc0, 4);
    chk("clr_pre_pass", pc0, 3);
    @(negedge clk); iv0 = 1'b1; id0 = 32'd1000; clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0; iv0 = 1'b0;
    chk("clr_col_cnt", cc0, 0);
    chk("clr_pass_cnt", pc0, 0);
    chk("clr_data_zero", od0 == '0, 1);
    chk("clr_in_ready", ir0, 1);
    beat0(32'd3);
    chk("clr_after_col0", col0(0), 3);
    chk("clr_after_col4", col0(4), 0);
    @(negedge clk); iv0 = 1'b0; clr0 = 1'b1;
    @(posedge clk); #1; clr0 = 1'b0;

    // clr discards a pending row even with out_ready high
    for (int i = 0; i < OC*NP; i++) beat0(32'd1);
    chk("clrp_valid", ov0, 1);
    @(negedge clk); iv0 = 1'b0; clr0 = 1'b1; or0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0; or0 = 1'b0;
    chk("clrp_ov_low", ov0, 0);
    chk("clrp_zero", od0 == '0, 1);

    // asynchronous reset mid-row at pass 12
    for (int i = 0; i < 12*OC + 3; i++) beat0(32'd5);
    chk("rstm_pre_pass", pc0, 12);
    @(negedge clk); iv0 = 1'b0;
    #2; rstn = 1'b0; #1;
    chk("rstm_col_cnt", cc0, 0);
    chk("rstm_pass_cnt", pc0, 0);
    chk("rstm_ov", ov0, 0);
    chk("rstm_zero", od0 == '0, 1);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < OC*NP; i++) beat0(32'd2);
    chk("rstm_valid", ov0, 1);
    for (int c = 0; c < OC; c++) chk("rstm_col", col0(c), 60);
    drain0("rstm_drain");

    // randomized rows on the default instance against an integer model
    for (int r = 0; r < 3; r++) begin
      int cnt;
      int guard;
      mdl = '{default: 0};
      cnt = 0; guard = 0;
      while (cnt < OC*NP && guard < 5000) begin
        @(negedge clk);
        iv0 = (($urandom % 4) != 0);
        id0 = $urandom;
        chk("rnd_in_ready", ir0, 1);
        if (iv0) begin
          mdl[cnt % OC] += int'($signed(id0));
          cnt++;
        end
        @(posedge clk); #1;
        guard++;
        if (cnt < OC*NP) begin
          chk("rnd_col_cnt", cc0, cnt % OC);
          chk("rnd_pass_cnt", pc0, cnt / OC);
          chk("rnd_pass_start", ps0, (cnt % OC) == 0);
          chk("rnd_ov_low", ov0, 0);
        end
      end
      chk("rnd_row_done", cnt, OC*NP);
      chk("rnd_valid", ov0, 1);
      for (int c = 0; c < OC; c++) chk("rnd_col", col0(c), mdl[c]);
      repeat ($urandom % 4) begin
        @(negedge clk); iv0 = 1'b1;
        @(posedge clk); #1;
        chk("rnd_bp_valid", ov0, 1);
      end
      drain0("rnd_drain");
    end

    // randomized 8-bit rows: saturating and wrapping models
    for (int r = 0; r < 20; r++) begin
      ms = '{default: 0};
      mw = '{default: 0};
      for (int i = 0; i < SOC*SNP; i++) begin
        int v;
        v = int'($urandom_range(255)) - 128;
        ms[i % SOC] = ms[i % SOC] + v;
        if (ms[i % SOC] > 127) ms[i % SOC] = 127;
        if (ms[i % SOC] < -128) ms[i % SOC] = -128;
        mw[i % SOC] = int'(byte'(mw[i % SOC] + v));
        beat_s(8'(v));
      end
      chk("srnd_valid", ov1 & ov2, 1);
      for (int c = 0; c < SOC; c++) begin
        chk("srnd_sat_col", col1(c), ms[c]);
        chk("srnd_wrap_col", col2(c), mw[c]);
      end
      drain_s("srnd_drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
